// File: rtl/deparser_sched.sv
// deparser_sched: shares one axis_deparser between PORTS header+payload channels.
// Round-robin by default; define DEPARSER_SCHED_PRIO_EN for fixed lowest-index priority.
module deparser_sched #(
    parameter int PORTS          = 4,
    parameter int DATA_WIDTH     = 512,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int HDR_DATA_WIDTH = 560,
    parameter int HDR_KEEP_WIDTH = HDR_DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int DEST_WIDTH     = 4,
    parameter int USER_WIDTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [PORTS*HDR_DATA_WIDTH-1:0]  s_axis_hdr_tdata,
    input  logic [PORTS*HDR_KEEP_WIDTH-1:0]  s_axis_hdr_tkeep,
    input  logic [PORTS-1:0]                 s_axis_hdr_tvalid,
    output logic [PORTS-1:0]                 s_axis_hdr_tready,
    input  logic [PORTS-1:0]                 s_axis_hdr_tlast,
    input  logic [PORTS*ID_WIDTH-1:0]        s_axis_hdr_tid,
    input  logic [PORTS*DEST_WIDTH-1:0]      s_axis_hdr_tdest,
    input  logic [PORTS*USER_WIDTH-1:0]      s_axis_hdr_tuser,

    input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep,
    input  logic [PORTS-1:0]                 s_axis_tvalid,
    output logic [PORTS-1:0]                 s_axis_tready,
    input  logic [PORTS-1:0]                 s_axis_tlast,
    input  logic [PORTS*ID_WIDTH-1:0]        s_axis_tid,
    input  logic [PORTS*DEST_WIDTH-1:0]      s_axis_tdest,
    input  logic [PORTS*USER_WIDTH-1:0]      s_axis_tuser,

    output logic [HDR_DATA_WIDTH-1:0]        m_axis_hdr_tdata,
    output logic [HDR_KEEP_WIDTH-1:0]        m_axis_hdr_tkeep,
    output logic                             m_axis_hdr_tvalid,
    input  logic                             m_axis_hdr_tready,
    output logic                             m_axis_hdr_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_hdr_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_hdr_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_hdr_tuser,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,

    output logic [PORTS-1:0]                 grant,
    output logic                             busy,
    output logic [1:0]                       dbg_state
);

    localparam int IDX_W = $clog2(PORTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PORTS-1:0] req;
    logic             any_req;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] g_idx;
    logic             active;
    logic             hdr_phase;
    logic             hdr_hs;
    logic             pay_last_hs;

    // A lane may only request once its header and first payload beat are both valid,
    // since the deparser takes them together.
    assign req     = s_axis_hdr_tvalid & s_axis_tvalid;
    assign any_req = |req;

    // Handshakes are plain AXIS: a beat moves on the rising edge where tvalid and
    // tready are both high; sources hold tvalid and data until that edge.
    assign hdr_hs      = m_axis_hdr_tvalid && m_axis_hdr_tready;
    assign pay_last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Reset gates every handshake combinationally so nothing moves while rst is high.
    assign active    = !rst && (state != ST_IDLE);
    assign hdr_phase = active && (state == ST_HDR);
    assign busy      = active;
    assign dbg_state = state;

`ifdef DEPARSER_SCHED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (req[k]) winner = IDX_W'(k);
        end
    end
`else
    logic [IDX_W-1:0] last_ptr;
    logic             found;
    int               cand;

    // Search starts one past the last winner so the lane that just finished goes last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = (int'(last_ptr) + k) % PORTS;
            if (!found && req[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr <= IDX_W'(PORTS - 1);
        end else if (state == ST_IDLE && any_req) begin
            last_ptr <= winner;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            g_idx <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any_req) begin
                grant <= {{(PORTS-1){1'b0}}, 1'b1} << winner;
                g_idx <= winner;
            end else if (state != ST_IDLE && state_next == ST_IDLE) begin
                grant <= '0;
                g_idx <= '0;
            end
        end
    end

    // A tlast payload beat accepted together with the header closes the packet at once.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_req) state_next = ST_HDR;
            ST_HDR: begin
                if (hdr_hs && pay_last_hs) state_next = ST_IDLE;
                else if (hdr_hs)           state_next = ST_PAY;
            end
            ST_PAY:  if (pay_last_hs) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // g_idx rests at 0 while idle, so the data fields then mirror lane 0 with valid low.
    always_comb begin
        m_axis_hdr_tdata  = s_axis_hdr_tdata[g_idx*HDR_DATA_WIDTH +: HDR_DATA_WIDTH];
        m_axis_hdr_tkeep  = s_axis_hdr_tkeep[g_idx*HDR_KEEP_WIDTH +: HDR_KEEP_WIDTH];
        m_axis_hdr_tlast  = s_axis_hdr_tlast[g_idx];
        m_axis_hdr_tid    = s_axis_hdr_tid[g_idx*ID_WIDTH +: ID_WIDTH];
        m_axis_hdr_tdest  = s_axis_hdr_tdest[g_idx*DEST_WIDTH +: DEST_WIDTH];
        m_axis_hdr_tuser  = s_axis_hdr_tuser[g_idx*USER_WIDTH +: USER_WIDTH];
        m_axis_hdr_tvalid = hdr_phase && s_axis_hdr_tvalid[g_idx];

        m_axis_tdata      = s_axis_tdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep      = s_axis_tkeep[g_idx*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tlast      = s_axis_tlast[g_idx];
        m_axis_tid        = s_axis_tid[g_idx*ID_WIDTH +: ID_WIDTH];
        m_axis_tdest      = s_axis_tdest[g_idx*DEST_WIDTH +: DEST_WIDTH];
        m_axis_tuser      = s_axis_tuser[g_idx*USER_WIDTH +: USER_WIDTH];
        m_axis_tvalid     = active && s_axis_tvalid[g_idx];

        s_axis_hdr_tready        = '0;
        s_axis_tready            = '0;
        s_axis_hdr_tready[g_idx] = hdr_phase && m_axis_hdr_tready;
        s_axis_tready[g_idx]     = active && m_axis_tready;
    end

endmodule

// File: tb/tb_deparser_sched.sv
// Self-checking bench for deparser_sched: per-lane drivers feed an expected-queue
// scoreboard that a monitor on the m_* side pops and compares.
module tb_deparser_sched;

    localparam int PORTS  = 4;
    localparam int P_DW   = 32;
    localparam int P_KW   = P_DW / 8;
    localparam int H_DW   = 48;
    localparam int H_KW   = H_DW / 8;
    localparam int ID_W   = 8;
    localparam int DEST_W = 4;
    localparam int USER_W = 4;

    localparam int O_ID    = USER_W + DEST_W;
    localparam int O_LAST  = O_ID + ID_W;
    localparam int O_KEEP  = O_LAST + 1;
    localparam int OH_DATA = O_KEEP + H_KW;
    localparam int OP_DATA = O_KEEP + P_KW;
    localparam int HB      = OH_DATA + H_DW;
    localparam int PB      = OP_DATA + P_DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [PORTS*H_DW-1:0]   s_axis_hdr_tdata  = '0;
    logic [PORTS*H_KW-1:0]   s_axis_hdr_tkeep  = '0;
    logic [PORTS-1:0]        s_axis_hdr_tvalid = '0;
    logic [PORTS-1:0]        s_axis_hdr_tready;
    logic [PORTS-1:0]        s_axis_hdr_tlast  = '0;
    logic [PORTS*ID_W-1:0]   s_axis_hdr_tid    = '0;
    logic [PORTS*DEST_W-1:0] s_axis_hdr_tdest  = '0;
    logic [PORTS*USER_W-1:0] s_axis_hdr_tuser  = '0;
    logic [PORTS*P_DW-1:0]   s_axis_tdata      = '0;
    logic [PORTS*P_KW-1:0]   s_axis_tkeep      = '0;
    logic [PORTS-1:0]        s_axis_tvalid     = '0;
    logic [PORTS-1:0]        s_axis_tready;
    logic [PORTS-1:0]        s_axis_tlast      = '0;
    logic [PORTS*ID_W-1:0]   s_axis_tid        = '0;
    logic [PORTS*DEST_W-1:0] s_axis_tdest      = '0;
    logic [PORTS*USER_W-1:0] s_axis_tuser      = '0;

    logic [H_DW-1:0]   m_axis_hdr_tdata;
    logic [H_KW-1:0]   m_axis_hdr_tkeep;
    logic              m_axis_hdr_tvalid;
    logic              m_axis_hdr_tready = 1'b1;
    logic              m_axis_hdr_tlast;
    logic [ID_W-1:0]   m_axis_hdr_tid;
    logic [DEST_W-1:0] m_axis_hdr_tdest;
    logic [USER_W-1:0] m_axis_hdr_tuser;
    logic [P_DW-1:0]   m_axis_tdata;
    logic [P_KW-1:0]   m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic [ID_W-1:0]   m_axis_tid;
    logic [DEST_W-1:0] m_axis_tdest;
    logic [USER_W-1:0] m_axis_tuser;
    logic [PORTS-1:0]  grant;
    logic              busy;
    logic [1:0]        dbg_state;

    deparser_sched #(
        .PORTS(PORTS), .DATA_WIDTH(P_DW), .KEEP_WIDTH(P_KW),
        .HDR_DATA_WIDTH(H_DW), .HDR_KEEP_WIDTH(H_KW),
        .ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W), .USER_WIDTH(USER_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_hdr_tdata(s_axis_hdr_tdata), .s_axis_hdr_tkeep(s_axis_hdr_tkeep),
        .s_axis_hdr_tvalid(s_axis_hdr_tvalid), .s_axis_hdr_tready(s_axis_hdr_tready),
        .s_axis_hdr_tlast(s_axis_hdr_tlast), .s_axis_hdr_tid(s_axis_hdr_tid),
        .s_axis_hdr_tdest(s_axis_hdr_tdest), .s_axis_hdr_tuser(s_axis_hdr_tuser),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .m_axis_hdr_tdata(m_axis_hdr_tdata), .m_axis_hdr_tkeep(m_axis_hdr_tkeep),
        .m_axis_hdr_tvalid(m_axis_hdr_tvalid), .m_axis_hdr_tready(m_axis_hdr_tready),
        .m_axis_hdr_tlast(m_axis_hdr_tlast), .m_axis_hdr_tid(m_axis_hdr_tid),
        .m_axis_hdr_tdest(m_axis_hdr_tdest), .m_axis_hdr_tuser(m_axis_hdr_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
        .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    int checks = 0;
    int errors = 0;
    logic [HB-1:0] exp_hdr_q[PORTS][$];
    logic [PB-1:0] exp_pay_q[PORTS][$];
    int got_lane_q[$];
    int seq_n[PORTS];
    int hdr_viol = 0;
    int rdy_viol = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [HB-1:0] make_hdr(input int lane);
        logic [H_DW-1:0] d;
        logic [ID_W-1:0] id;
        d  = H_DW'({$urandom(), $urandom()});
        id = ID_W'((lane << 4) | (seq_n[lane] & 15));
        return {d, H_KW'($urandom()), 1'b1, id, DEST_W'(lane), USER_W'($urandom())};
    endfunction

    function automatic logic [PB-1:0] make_pay(input int lane, input int beat, input bit last);
        logic [ID_W-1:0] id;
        id = ID_W'((lane << 4) | (beat & 15));
        return {P_DW'($urandom()), P_KW'($urandom()), last, id, DEST_W'(lane), USER_W'($urandom())};
    endfunction

    task automatic put_hdr(input int lane, input logic [HB-1:0] h);
        s_axis_hdr_tdata[lane*H_DW +: H_DW]       = h[OH_DATA +: H_DW];
        s_axis_hdr_tkeep[lane*H_KW +: H_KW]       = h[O_KEEP +: H_KW];
        s_axis_hdr_tlast[lane]                    = h[O_LAST];
        s_axis_hdr_tid[lane*ID_W +: ID_W]         = h[O_ID +: ID_W];
        s_axis_hdr_tdest[lane*DEST_W +: DEST_W]   = h[USER_W +: DEST_W];
        s_axis_hdr_tuser[lane*USER_W +: USER_W]   = h[0 +: USER_W];
        s_axis_hdr_tvalid[lane]                   = 1'b1;
    endtask

    task automatic put_pay(input int lane, input logic [PB-1:0] p);
        s_axis_tdata[lane*P_DW +: P_DW]       = p[OP_DATA +: P_DW];
        s_axis_tkeep[lane*P_KW +: P_KW]       = p[O_KEEP +: P_KW];
        s_axis_tlast[lane]                    = p[O_LAST];
        s_axis_tid[lane*ID_W +: ID_W]         = p[O_ID +: ID_W];
        s_axis_tdest[lane*DEST_W +: DEST_W]   = p[USER_W +: DEST_W];
        s_axis_tuser[lane*USER_W +: USER_W]   = p[0 +: USER_W];
        s_axis_tvalid[lane]                   = 1'b1;
    endtask

    // Called at a falling edge with the beat driven; returns at the falling edge after the handshake.
    task automatic wait_hs(input int lane, input bit is_hdr);
        int n;
        n = 0;
        forever begin
            #1;
            if (is_hdr ? s_axis_hdr_tready[lane] : s_axis_tready[lane]) break;
            n++;
            if (n > 200) begin
                check_eq(is_hdr ? "hdr_timeout" : "pay_timeout", 128'(0), 128'(1));
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic drive_hdr(input int lane);
        logic [HB-1:0] h;
        h = make_hdr(lane);
        seq_n[lane]++;
        exp_hdr_q[lane].push_back(h);
        put_hdr(lane, h);
        wait_hs(lane, 1'b1);
        s_axis_hdr_tvalid[lane] = 1'b0;
    endtask

    task automatic drive_pay(input int lane, input int nbeats, input int delay);
        logic [PB-1:0] p;
        repeat (delay) @(negedge clk);
        for (int b = 0; b < nbeats; b++) begin
            p = make_pay(lane, b, b == nbeats - 1);
            exp_pay_q[lane].push_back(p);
            put_pay(lane, p);
            wait_hs(lane, 1'b0);
        end
        s_axis_tvalid[lane] = 1'b0;
    endtask

    task automatic lane_pkts(input int lane, input int npkts, input int nbeats);
        for (int k = 0; k < npkts; k++) begin
            fork
                drive_hdr(lane);
                drive_pay(lane, nbeats, 0);
            join
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_grant"}, 128'(grant), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_s_rdy"}, 128'({s_axis_hdr_tready, s_axis_tready}), 128'(0));
        check_eq({tag, "_m_vld"}, 128'({m_axis_hdr_tvalid, m_axis_tvalid}), 128'(0));
    endtask

    // Monitor: decides each cycle, between edges, which m_* beats will be accepted.
    initial begin
        int lane;
        bit in_pay;
        logic [HB-1:0] hv;
        logic [PB-1:0] pv;
        in_pay = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                in_pay = 1'b0;
            end else begin
                if (in_pay && |s_axis_hdr_tready) hdr_viol++;
                if (|((s_axis_tready | s_axis_hdr_tready) & ~grant)) rdy_viol++;
                lane = 0;
                for (int i = 0; i < PORTS; i++) if (grant[i]) lane = i;
                if (m_axis_hdr_tvalid && m_axis_hdr_tready) begin
                    check_eq("hdr_grant_onehot", 128'($onehot(grant)), 128'(1));
                    got_lane_q.push_back(lane);
                    hv = {m_axis_hdr_tdata, m_axis_hdr_tkeep, m_axis_hdr_tlast,
                          m_axis_hdr_tid, m_axis_hdr_tdest, m_axis_hdr_tuser};
                    if (exp_hdr_q[lane].size() == 0)
                        check_eq("hdr_unexpected", 128'(hv), 128'(0));
                    else
                        check_eq("hdr_beat", 128'(hv), 128'(exp_hdr_q[lane].pop_front()));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    check_eq("pay_grant_onehot", 128'($onehot(grant)), 128'(1));
                    pv = {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                          m_axis_tid, m_axis_tdest, m_axis_tuser};
                    if (exp_pay_q[lane].size() == 0)
                        check_eq("pay_unexpected", 128'(pv), 128'(0));
                    else
                        check_eq("pay_beat", 128'(pv), 128'(exp_pay_q[lane].pop_front()));
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) in_pay = 1'b0;
                else if (m_axis_hdr_tvalid && m_axis_hdr_tready) in_pay = 1'b1;
            end
        end
    end

    // Main sequence
    initial begin
        logic [HB-1:0] h;
        logic [PB-1:0] p;
        int exp_rr[8];
        for (int i = 0; i < PORTS; i++) seq_n[i] = 0;

        // Reset
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("in_reset");
        check_eq("in_reset_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("after_reset");

        // All lanes requesting continuously, one-beat payloads
        @(negedge clk);
        got_lane_q.delete();
        fork
            lane_pkts(0, 2, 1);
            lane_pkts(1, 2, 1);
            lane_pkts(2, 2, 1);
            lane_pkts(3, 2, 1);
        join
        for (int i = 0; i < 8; i++) begin
`ifdef DEPARSER_SCHED_PRIO_EN
            exp_rr[i] = i / 2;
`else
            exp_rr[i] = i % 4;
`endif
        end
        check_eq("rr_count", 128'(got_lane_q.size()), 128'(8));
        for (int i = 0; i < 8 && i < got_lane_q.size(); i++)
            check_eq("rr_order", 128'(got_lane_q[i]), 128'(exp_rr[i]));

        // Single lane 2, 3-beat payload
        repeat (2) @(negedge clk);
        got_lane_q.delete();
        fork
            drive_hdr(2);
            drive_pay(2, 3, 0);
            begin
                #1;
                check_eq("single_no_grant_yet", 128'(grant), 128'(0));
                @(negedge clk);
                #1;
                check_eq("single_grant", 128'(grant), 128'(4'b0100));
                check_eq("single_busy", 128'(busy), 128'(1));
            end
        join
        #1;
        check_eq("single_grant_cleared", 128'(grant), 128'(0));
        check_eq("single_busy_cleared", 128'(busy), 128'(0));
        check_eq("single_lane", 128'(got_lane_q.size() == 1 && got_lane_q[0] == 2), 128'(1));

        // Backpressure on lane 1 mid-payload
        repeat (2) @(negedge clk);
        fork
            drive_hdr(1);
            drive_pay(1, 4, 0);
            begin
                repeat (2) @(negedge clk);
                m_axis_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check_eq("bp_grant_held", 128'(grant), 128'(4'b0010));
                    check_eq("bp_stalled", 128'({m_axis_tvalid, s_axis_tready[1]}), 128'(2'b10));
                    @(negedge clk);
                end
                m_axis_tready = 1'b1;
            end
        join

        // Header valid on lane 3 without payload
        repeat (2) @(negedge clk);
        fork
            drive_hdr(3);
            drive_pay(3, 2, 4);
            begin
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check_eq("hdr_only_no_grant", 128'(grant), 128'(0));
                    @(negedge clk);
                end
                #1;
                check_eq("hdr_only_grant", 128'(grant), 128'(4'b1000));
            end
        join

        // Lane 0 presents a second header while its first packet is still in flight
        repeat (2) @(negedge clk);
        got_lane_q.delete();
        fork
            begin
                drive_hdr(0);
                drive_hdr(0);
            end
            begin
                drive_pay(0, 3, 0);
                drive_pay(0, 1, 0);
            end
            begin
                repeat (2) @(negedge clk);
                #1;
                check_eq("b2b_hdr_rdy_pay1", 128'(s_axis_hdr_tready[0]), 128'(0));
                @(negedge clk);
                #1;
                check_eq("b2b_hdr_rdy_pay2", 128'(s_axis_hdr_tready[0]), 128'(0));
                @(negedge clk);
                #1;
                check_eq("b2b_idle_gap", 128'({grant, m_axis_hdr_tvalid}), 128'(0));
                @(negedge clk);
                #1;
                check_eq("b2b_second_hdr", 128'({grant, m_axis_hdr_tvalid, s_axis_hdr_tready[0]}),
                         128'({4'b0001, 2'b11}));
            end
        join
        check_eq("b2b_lanes", 128'(got_lane_q.size() == 2 && got_lane_q[0] == 0 && got_lane_q[1] == 0),
                 128'(1));

        // Reset pulsed during the second of four payload beats on lane 1
        repeat (2) @(negedge clk);
        h = make_hdr(1);
        exp_hdr_q[1].push_back(h);
        put_hdr(1, h);
        p = make_pay(1, 0, 1'b0);
        exp_pay_q[1].push_back(p);
        put_pay(1, p);
        @(negedge clk);
        #1;
        check_eq("rst_pre_grant", 128'(grant), 128'(4'b0010));
        @(negedge clk);
        s_axis_hdr_tvalid[1] = 1'b0;
        p = make_pay(1, 1, 1'b0);
        put_pay(1, p);
        rst = 1'b1;
        #1;
        check_eq("rst_during_rdy", 128'({s_axis_hdr_tready, s_axis_tready}), 128'(0));
        check_eq("rst_during_vld", 128'({m_axis_hdr_tvalid, m_axis_tvalid}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid[1] = 1'b0;
        #1;
        check_idle_outputs("rst_after");
        @(negedge clk);
        got_lane_q.delete();
        fork
            lane_pkts(1, 1, 1);
            lane_pkts(0, 1, 1);
        join
        check_eq("rst_prio_count", 128'(got_lane_q.size()), 128'(2));
        if (got_lane_q.size() == 2) begin
            check_eq("rst_prio_first", 128'(got_lane_q[0]), 128'(0));
            check_eq("rst_prio_second", 128'(got_lane_q[1]), 128'(1));
        end

        // Final report
        repeat (3) @(negedge clk);
        for (int i = 0; i < PORTS; i++) begin
            check_eq("hdr_q_drained", 128'(exp_hdr_q[i].size()), 128'(0));
            check_eq("pay_q_drained", 128'(exp_pay_q[i].size()), 128'(0));
        end
        check_eq("hdr_ready_in_pay", 128'(hdr_viol), 128'(0));
        check_eq("ready_to_ungranted", 128'(rdy_viol), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
